// File: rtl/pmcc_pkg.sv
// Shared types and constants for the PMC code loader.
// Optional readback verify is enabled by defining PMCC_CODE_LOADER_VERIFY_EN.
package pmcc_pkg;

  // Size of the PMC code RAM in 32-bit words (10-bit word address space).
  localparam int unsigned PMCC_CODE_WORDS = 1024;

  // Byte enable for a full 32-bit word access.
  localparam logic [3:0] PMCC_BE_FULL = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrReq,
    StWrResp,
`ifdef PMCC_CODE_LOADER_VERIFY_EN
    StRdReq,
    StRdResp,
`endif
    StDone
  } pmcc_state_e;

endpackage

// File: rtl/pmcc_code_loader.sv
// PMC code loader: copies a stream of source words into the PMC code RAM over the
// data bus, one outstanding transaction at a time.
// Define PMCC_CODE_LOADER_VERIFY_EN to read back and compare every written word.
module pmcc_code_loader
  import pmcc_pkg::*;
#(
  parameter int unsigned MAX_WORDS = PMCC_CODE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [10:0] word_count,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  // Initiator side of the code RAM data bus
  output logic        data_bus_req,
  input  logic        data_bus_gnt,
  input  logic        data_bus_rvalid,
  output logic [31:0] data_bus_addr,
  output logic        data_bus_we,
  output logic [3:0]  data_bus_be,
  output logic [31:0] data_bus_wdata,
  input  logic [31:0] data_bus_rdata,
  input  logic        data_bus_err
);

  localparam logic [10:0] MaxWords = 11'(MAX_WORDS);

  pmcc_state_e state_q;
  logic [10:0] count_q;
  logic [10:0] target_q;
  logic [10:0] count_inc;
  logic        last_word;
  logic        start_bad;

  // Progress and request sanity decode
  assign count_inc = count_q + 11'd1;
  assign last_word = (count_inc == target_q);
  assign start_bad = (word_count > MaxWords) || (base_addr[1:0] != 2'b00);

`ifndef PMCC_CODE_LOADER_VERIFY_EN
  // Read data is only consumed by the verify comparator.
  logic unused_rdata;
  assign unused_rdata = ^data_bus_rdata;
`endif

  // Loader FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= 11'd0;
      target_q       <= 11'd0;
      src_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      data_bus_req   <= 1'b0;
      data_bus_addr  <= 32'd0;
      data_bus_we    <= 1'b0;
      data_bus_be    <= 4'h0;
      data_bus_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          // Late responses from an abandoned transaction are ignored here.
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else if (word_count == 11'd0) begin
              err     <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              err           <= 1'b0;
              busy          <= 1'b1;
              src_ready     <= 1'b1;
              count_q       <= 11'd0;
              target_q      <= word_count;
              data_bus_addr <= base_addr;
              state_q       <= StFetch;
            end
          end
        end
        StFetch: begin
          if (src_valid) begin
            src_ready      <= 1'b0;
            data_bus_req   <= 1'b1;
            data_bus_we    <= 1'b1;
            data_bus_be    <= PMCC_BE_FULL;
            data_bus_wdata <= src_data;
            state_q        <= StWrReq;
          end
        end
        StWrReq: begin
          if (data_bus_gnt) begin
            data_bus_req <= 1'b0;
            state_q      <= StWrResp;
          end
        end
        StWrResp: begin
          if (data_bus_rvalid) begin
            if (data_bus_err) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
`ifdef PMCC_CODE_LOADER_VERIFY_EN
              // Read back the same address; wdata keeps the reference word.
              data_bus_req <= 1'b1;
              data_bus_we  <= 1'b0;
              state_q      <= StRdReq;
`else
              data_bus_addr <= data_bus_addr + 32'd4;
              count_q       <= count_inc;
              if (last_word) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StDone;
              end else begin
                src_ready <= 1'b1;
                state_q   <= StFetch;
              end
`endif
            end
          end
        end
`ifdef PMCC_CODE_LOADER_VERIFY_EN
        StRdReq: begin
          if (data_bus_gnt) begin
            data_bus_req <= 1'b0;
            state_q      <= StRdResp;
          end
        end
        StRdResp: begin
          if (data_bus_rvalid) begin
            if (data_bus_err || (data_bus_rdata != data_bus_wdata)) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              data_bus_addr <= data_bus_addr + 32'd4;
              count_q       <= count_inc;
              if (last_word) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StDone;
              end else begin
                src_ready <= 1'b1;
                state_q   <= StFetch;
              end
            end
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
